// File: rtl/mbist_controller.sv
// -----------------------------------------------------------------------------
// mbist_controller
//
// Memory built-in self-test controller running the March C- algorithm on a
// single-port SRAM. It also muxes the functional path onto the SRAM pins while
// the test engine is idle.
//
// March C- sequence (0 = all-zero background, 1 = all-ones background):
//   E0 up  (w0)        1 cycle per address  : WR
//   E1 up  (r0,w1)     3 cycles per address : RD_ISSUE, RD_CMP, WR
//   E2 up  (r1,w0)     3 cycles per address
//   E3 down(r0,w1)     3 cycles per address
//   E4 down(r1,w0)     3 cycles per address
//   E5 up  (r0)        2 cycles per address : RD_ISSUE, RD_CMP
//
// Ports
//   clk         : single clock, all state updates on the rising edge
//   rst         : synchronous, active-high reset
//   start       : request a self-test (only honoured when not busy)
//   func_addr   : functional-path address
//   func_din    : functional-path write data
//   func_rwbar  : functional-path read(1)/write(0)
//   func_cs     : functional-path chip select
//   ramout      : SRAM read data, valid the cycle after the read address edge
//   ramaddr     : SRAM address
//   ramin       : SRAM write data
//   rwbar       : SRAM read(1)/write(0)
//   cs          : SRAM chip select
//   busy        : test in progress, controller owns the SRAM
//   done        : test finished, held until the next start or rst
//   pass        : test result, meaningful only while done=1
//   fail_addr   : address of the first mismatch
//   fail_elem   : March element (0..5) of the first mismatch
//   fail_data   : ramout value seen at the first mismatch
// -----------------------------------------------------------------------------
module mbist_controller #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] func_addr,
  input  logic [DATA_W-1:0] func_din,
  input  logic              func_rwbar,
  input  logic              func_cs,
  input  logic [DATA_W-1:0] ramout,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramin,
  output logic              rwbar,
  output logic              cs,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_CMP,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [2:0]        ELEM_LAST = 3'd5;

  // Registered state
  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          elem_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [ADDR_W-1:0]   fail_addr_q;
  logic [2:0]          fail_elem_q;
  logic [DATA_W-1:0]   fail_data_q;

  // Address/element sequencing for "this address is finished"
  logic [ADDR_W-1:0]   addr_d;
  logic [2:0]          elem_d;
  logic                descending;
  logic                at_terminal;
  logic                next_descending;
  logic [2:0]          elem_inc;

  // Data backgrounds for the current element
  logic [DATA_W-1:0]   exp_data;
  logic [DATA_W-1:0]   wr_data;

  // ---------------------------------------------------------------------------
  // Element decode and next-address computation
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    descending      = 1'b0;
    at_terminal     = 1'b0;
    elem_inc        = elem_q + 3'd1;
    next_descending = 1'b0;
    exp_data        = '0;
    wr_data         = '0;
    addr_d          = addr_q;
    elem_d          = elem_q;

    // E3 and E4 walk the array from the top address down.
    descending      = (elem_q == 3'd3) || (elem_q == 3'd4);
    next_descending = (elem_inc == 3'd3) || (elem_inc == 3'd4);
    at_terminal     = descending ? (addr_q == '0) : (addr_q == ADDR_LAST);

    // E2/E4 read back ones; E1/E3/E5 read back zeros.
    if ((elem_q == 3'd2) || (elem_q == 3'd4)) begin
      exp_data = '1;
    end
    // E1/E3 write ones; E0/E2/E4 write zeros.
    if ((elem_q == 3'd1) || (elem_q == 3'd3)) begin
      wr_data = '1;
    end

    // At the terminal address the counter does not wrap: it jumps to the
    // start address of the next element instead.
    if (at_terminal) begin
      elem_d = elem_inc;
      addr_d = next_descending ? ADDR_LAST : '0;
    end else begin
      addr_d = descending ? (addr_q - 1'b1) : (addr_q + 1'b1);
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: all state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, matching the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      elem_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_data_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // DONE behaves like IDLE apart from holding the result flags.
          if (start) begin
            state_q     <= WR;
            addr_q      <= '0;
            elem_q      <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_data_q <= '0;
          end
        end

        WR: begin
          // A write is always the last cycle of its address.
          addr_q <= addr_d;
          elem_q <= elem_d;
          // Only E0 is write-only; every later element opens with a read.
          state_q <= ((elem_q == 3'd0) && !at_terminal) ? WR : RD_ISSUE;
        end

        RD_ISSUE: begin
          state_q <= RD_CMP;
        end

        RD_CMP: begin
          if (ramout != exp_data) begin
            // First mismatch ends the test; the SRAM is released at once.
            fail_addr_q <= addr_q;
            fail_elem_q <= elem_q;
            fail_data_q <= ramout;
            pass_q      <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end else if (elem_q == ELEM_LAST) begin
            // E5 is read-only, so the compare is the last cycle here.
            if (at_terminal) begin
              pass_q  <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              addr_q  <= addr_d;
              state_q <= RD_ISSUE;
            end
          end else begin
            state_q <= WR;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM pin mux: functional path passes straight through while idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    ramaddr = func_addr;
    ramin   = func_din;
    rwbar   = func_rwbar;
    cs      = func_cs;
    if (busy_q) begin
      ramaddr = addr_q;
      ramin   = wr_data;
      rwbar   = (state_q != WR);
      cs      = 1'b1;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign fail_data = fail_data_q;

endmodule

// File: tb/tb_mbist_controller.sv
// -----------------------------------------------------------------------------
// tb_mbist_controller
//
// Bench for mbist_controller. A behavioural SRAM with per-address stuck-at
// masks sits on the SRAM pins. For every test run a reference model walks the
// March C- elements over its own copy of the memory and queues the expected
// per-cycle SRAM accesses and the final result; a monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_mbist_controller;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] func_addr;
  logic [DW-1:0] func_din;
  logic          func_rwbar;
  logic          func_cs;
  logic [DW-1:0] ramout;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramin;
  logic          rwbar;
  logic          cs;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_data;

  mbist_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .func_addr  (func_addr),
    .func_din   (func_din),
    .func_rwbar (func_rwbar),
    .func_cs    (func_cs),
    .ramout     (ramout),
    .ramaddr    (ramaddr),
    .ramin      (ramin),
    .rwbar      (rwbar),
    .cs         (cs),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_addr  (fail_addr),
    .fail_elem  (fail_elem),
    .fail_data  (fail_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural SRAM with stuck-at faults applied on read
  // ---------------------------------------------------------------------------
  logic [DW-1:0] sram [DEPTH];
  logic [DW-1:0] sa0  [DEPTH];
  logic [DW-1:0] sa1  [DEPTH];

  always @(posedge clk) begin
    if (cs && !rwbar) sram[ramaddr] <= ramin;
    ramout <= (cs && rwbar) ? ((sram[ramaddr] & ~sa0[ramaddr]) | sa1[ramaddr]) : '0;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [AW-1:0] addr;
    logic          rw;
    logic [DW-1:0] data;
  } acc_t;

  typedef struct {
    int            cycles;
    logic          pass;
    logic [2:0]    elem;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } res_t;

  acc_t exp_acc_q[$];
  res_t exp_res_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < DEPTH; i++) begin
      sa0[i] = '0;
      sa1[i] = '0;
    end
  endtask

  // Reference model: walk March C- element by element over an ideal memory
  // seen through the same fault masks, queueing every expected bus cycle.
  task automatic push_expected();
    logic [DW-1:0] m [DEPTH];
    logic [DW-1:0] bg;
    logic [DW-1:0] rv;
    int            ad;
    bit            failed;
    res_t          r;
    failed   = 1'b0;
    r.cycles = 0;
    r.pass   = 1'b1;
    r.elem   = '0;
    r.addr   = '0;
    r.data   = '0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (failed) break;
        ad = (e == 3 || e == 4) ? DEPTH - 1 - k : k;
        bg = (e == 2 || e == 4) ? 8'hFF : 8'h00;
        if (e == 0) begin
          exp_acc_q.push_back('{addr: ad[AW-1:0], rw: 1'b0, data: 8'h00});
          m[ad] = 8'h00;
          r.cycles++;
        end else begin
          exp_acc_q.push_back('{addr: ad[AW-1:0], rw: 1'b1, data: 8'h00});
          exp_acc_q.push_back('{addr: ad[AW-1:0], rw: 1'b1, data: 8'h00});
          r.cycles += 2;
          rv = (m[ad] & ~sa0[ad]) | sa1[ad];
          if (rv !== bg) begin
            failed = 1'b1;
            r.pass = 1'b0;
            r.elem = e[2:0];
            r.addr = ad[AW-1:0];
            r.data = rv;
          end else if (e != 5) begin
            exp_acc_q.push_back('{addr: ad[AW-1:0], rw: 1'b0, data: ~bg});
            m[ad] = ~bg;
            r.cycles++;
          end
        end
      end
    end
    exp_res_q.push_back(r);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  int   busy_cycles = 0;
  logic prev_done   = 1'b0;

  always @(negedge clk) begin
    acc_t a;
    res_t r;
    if (busy) begin
      busy_cycles++;
      if (exp_acc_q.size() == 0) begin
        check("extra_busy_cycle", 32'd1, 32'd0);
      end else begin
        a = exp_acc_q.pop_front();
        check("acc_addr", 32'(ramaddr), 32'(a.addr));
        check("acc_rwbar", 32'(rwbar), 32'(a.rw));
        check("acc_cs", 32'(cs), 32'd1);
        if (!a.rw) check("acc_wdata", 32'(ramin), 32'(a.data));
      end
    end
    if (done && !prev_done) begin
      if (exp_res_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        r = exp_res_q.pop_front();
        check("res_cycles", 32'(busy_cycles), 32'(r.cycles));
        check("res_pass", 32'(pass), 32'(r.pass));
        check("res_fail_elem", 32'(fail_elem), 32'(r.elem));
        check("res_fail_addr", 32'(fail_addr), 32'(r.addr));
        check("res_fail_data", 32'(fail_data), 32'(r.data));
        check("res_acc_left", 32'(exp_acc_q.size()), 32'd0);
      end
    end
    if (!busy) begin
      check("pass_addr", 32'(ramaddr), 32'(func_addr));
      check("pass_din", 32'(ramin), 32'(func_din));
      check("pass_rwbar", 32'(rwbar), 32'(func_rwbar));
      check("pass_cs", 32'(cs), 32'(func_cs));
      busy_cycles = 0;
    end
    prev_done = done;
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic idle_func();
    start      = 1'b0;
    func_cs    = 1'b0;
    func_rwbar = 1'b1;
    func_addr  = AW'($urandom);
    func_din   = DW'($urandom);
  endtask

  // One self-test. reset_cycle > 0 aborts the run with rst in that busy cycle.
  task automatic run_test(input int reset_cycle);
    push_expected();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; ; c++) begin
      if (!busy) break;
      if (c > 3000) begin
        check("run_timeout", 32'd0, 32'd1);
        break;
      end
      if (reset_cycle > 0 && c == reset_cycle) begin
        // Start asserted alongside rst: reset must win.
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        exp_acc_q.delete();
        exp_res_q.delete();
        @(negedge clk); #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_pass", 32'(pass), 32'd0);
        check("midrst_fail_addr", 32'(fail_addr), 32'd0);
        idle_func();
        return;
      end
      // Noise on start and the functional path must not disturb the run.
      start      = 1'($urandom_range(0, 1));
      func_cs    = 1'($urandom_range(0, 1));
      func_rwbar = 1'($urandom_range(0, 1));
      func_addr  = AW'($urandom);
      func_din   = DW'($urandom);
      @(posedge clk); #1;
    end
    idle_func();
    @(negedge clk); #1;
    check("res_consumed", 32'(exp_res_q.size()), 32'd0);
    check("done_held", 32'(done), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      func_addr = AW'($urandom);
      func_din  = DW'($urandom);
    end
    check("done_still_held", 32'(done), 32'd1);
  endtask

  initial begin
    int fa;
    int fb;
    rst = 1'b1;
    idle_func();
    clear_faults();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_fail_addr", 32'(fail_addr), 32'd0);
    check("rst_fail_elem", 32'(fail_elem), 32'd0);
    check("rst_fail_data", 32'(fail_data), 32'd0);

    // Idle passthrough write then read of address 10.
    @(posedge clk); #1;
    func_cs = 1'b1; func_rwbar = 1'b0; func_addr = 6'd10; func_din = 8'hA5;
    @(posedge clk); #1;
    func_rwbar = 1'b1; func_din = 8'h00;
    @(posedge clk); #1;
    check("func_readback", 32'(ramout), 32'hA5);
    idle_func();

    // Fault-free run.
    run_test(0);
    check("clean_pass", 32'(pass), 32'd1);

    // Bit 3 of address 10 stuck at 0.
    clear_faults();
    sa0[10] = 8'h08;
    run_test(0);
    check("sa0_pass", 32'(pass), 32'd0);
    check("sa0_elem", 32'(fail_elem), 32'd2);
    check("sa0_addr", 32'(fail_addr), 32'd10);
    check("sa0_data", 32'(fail_data), 32'hF7);

    // Bit 0 of address 63 stuck at 1.
    clear_faults();
    sa1[63] = 8'h01;
    run_test(0);
    check("sa1_pass", 32'(pass), 32'd0);
    check("sa1_elem", 32'(fail_elem), 32'd1);
    check("sa1_addr", 32'(fail_addr), 32'd63);
    check("sa1_data", 32'(fail_data), 32'h01);

    // Reset in cycle 300, then a full clean run.
    clear_faults();
    run_test(300);
    run_test(0);
    check("after_rst_pass", 32'(pass), 32'd1);

    // Randomised single and double stuck-at faults.
    for (int t = 0; t < 5; t++) begin
      clear_faults();
      fa = $urandom_range(0, DEPTH - 1);
      fb = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 1) == 1) sa0[fa] = DW'(1 << $urandom_range(0, DW - 1));
      else                           sa1[fa] = DW'(1 << $urandom_range(0, DW - 1));
      if (t >= 3) sa1[fb] = sa1[fb] | DW'(1 << $urandom_range(0, DW - 1));
      run_test(0);
    end

    // Final clean run from DONE.
    clear_faults();
    run_test(0);
    check("final_pass", 32'(pass), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mbist_controller.md
MBIST_CONTROLLER -- requirements
Module: mbist_controller

Interface
REQ-001 SHALL have parameters: ADDR_W, default 6, SRAM address width; DATA_W, default 8, SRAM data width.
REQ-002 SHALL have ports: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have ports: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports: start  input  1  request a March C- self-test; sampled in IDLE only.
REQ-005 SHALL have ports: func_addr  input  ADDR_W  functional-path address.
REQ-006 SHALL have ports: func_din  input  DATA_W  functional-path write data.
REQ-007 SHALL have ports: func_rwbar  input  1  functional-path read(1)/write(0).
REQ-008 SHALL have ports: func_cs  input  1  functional-path chip select.
REQ-009 SHALL have ports: ramout  input  DATA_W  SRAM read data (valid the cycle after the read address is clocked; 0 when rwbar=0 or cs=0).
REQ-010 SHALL have ports: ramaddr  output  ADDR_W  SRAM address.
REQ-011 SHALL have ports: ramin  output  DATA_W  SRAM write data.
REQ-012 SHALL have ports: rwbar  output  1  SRAM read(1)/write(0).
REQ-013 SHALL have ports: cs  output  1  SRAM chip select.
REQ-014 SHALL have ports: busy  output  1  test in progress; SRAM owned by the controller.
REQ-015 SHALL have ports: done  output  1  test finished; held until next start or rst.
REQ-016 SHALL have ports: pass  output  1  result; valid only while done=1.
REQ-017 SHALL have ports: fail_addr  output  ADDR_W  address of first mismatch.
REQ-018 SHALL have ports: fail_elem  output  3  March element (0..5) of first mismatch.
REQ-019 SHALL have ports: fail_data  output  DATA_W  ramout value at first mismatch.

Function
REQ-020 SHALL run March C-: E0 ⇕w0; E1 ⇑(r0,w1); E2 ⇑(r1,w0); E3 ⇓(r0,w1); E4 ⇓(r1,w0); E5 ⇕r0. Here 0 = all-zero data and 1 = all-ones data; ⇑ is address 0→2^ADDR_W-1; ⇓ is the reverse; E0 and E5 run ascending.
REQ-021 SHALL implement the FSM states IDLE, WR, RD_ISSUE, RD_CMP, DONE.
REQ-022 SHALL, in IDLE with start=1, clear done/pass/fail_*, assert busy, and enter WR for E0 at address 0.
REQ-023 SHALL make each E0 address take 1 cycle (WR): cs=1, rwbar=0, ramin=background.
REQ-024 SHALL make each E1-E4 address take 3 cycles: RD_ISSUE (cs=1, rwbar=1), then RD_CMP (cs=1, rwbar=1, compare ramout to expected), then WR (cs=1, rwbar=0, inverted data).
REQ-025 SHALL make each E5 address take 2 cycles: RD_ISSUE, then RD_CMP.
REQ-026 SHALL hold ramaddr constant across all cycles of one address.
REQ-027 SHALL step the address counter on the last cycle of each address. At the terminal address (63 ascending, 0 descending) it SHALL advance to the next element and load that element's start address instead of wrapping.
REQ-028 SHALL take exactly 64 + 4*192 + 128 = 960 cycles per fault-free run with ADDR_W=6. done=1 SHALL be visible after the 960th rising edge following the edge that sampled start.
REQ-029 SHALL, on the first RD_CMP mismatch: capture fail_addr, fail_elem and fail_data; set pass=0; go to DONE on the next edge, with no further SRAM accesses.
REQ-030 SHALL, on completing E5 with no mismatch, go to DONE with pass=1.
REQ-031 SHALL, in DONE, hold busy=0 and done=1. start=1 SHALL restart the test exactly as from IDLE.
REQ-032 SHALL ignore start while busy=1.
REQ-033 SHALL, while busy=0, connect ramaddr/ramin/rwbar/cs combinationally from func_addr/func_din/func_rwbar/func_cs.
REQ-034 SHALL, while busy=1, ignore the func_* inputs.

Reset
REQ-035 SHALL, on rst=1 at a rising edge, enter IDLE regardless of state, including mid-test.
REQ-036 SHALL, on reset, set busy=0, done=0, pass=0, fail_addr=0, fail_elem=0, fail_data=0, and clear the address counter to 0.
REQ-037 SHALL give rst priority over start in the same cycle.
REQ-038 SHALL leave SRAM contents after a mid-test reset undefined; no restore is required.

Verification
REQ-039 Fault-free sram, start pulsed one cycle -> busy=1 for 960 cycles, then done=1, pass=1, and no cs=1 cycles after done.
REQ-040 Bit 3 of addr 10 stuck-at-0 -> done=1, pass=0, fail_elem=2, fail_addr=10, fail_data=0xF7.
REQ-041 Bit 0 of addr 63 stuck-at-1 -> done=1, pass=0, fail_elem=1, fail_addr=63, fail_data=0x01.
REQ-042 rst=1 at cycle 300 of a run -> the next cycle shows busy=0, done=0, pass=0; a new start then gives the full 960-cycle pass.
REQ-043 Idle passthrough: func write 0xA5 to addr 10, then func read of addr 10 -> ramout=0xA5. Asserting start during a run, or toggling func_* during a run -> no effect on the SRAM pins or on the cycle count.
REQ-044 Address sequence check: during E3, ramaddr steps 63,62,...,0 with three cycles per address; E4 begins at 63 on the edge after addr 0's WR cycle.
